// File: rtl/gmii_pkg.sv
// Shared constants, FSM state and result record for the GMII testframe receive path.
package gmii_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE  = 8'h55;
    localparam logic [7:0]  SFD_BYTE       = 8'hD5;
    localparam logic [31:0] CRC32_POLY     = 32'h04C1_1DB7;
    localparam logic [31:0] CRC32_RESIDUE  = 32'hC704_DD7B;
    localparam logic [31:0] NSEC_PER_SEC   = 32'd1_000_000_000;
    localparam logic [15:0] TRAILER_OCTETS = 16'd22;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRE,
        ST_DATA,
        ST_DROP
    } rx_state_e;

    typedef struct packed {
        logic [15:0] octets;
        logic        fcs_ok;
        logic        testframe;
        logic [63:0] seq;
        logic [47:0] tx_sec;
        logic [31:0] tx_nsec;
        logic [47:0] rx_sec;
        logic [29:0] rx_nsec;
    } testframe_result_t;

    function automatic logic [31:0] bitrev32(input logic [31:0] v);
        logic [31:0] r;
        for (int unsigned i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/crc32_d8.sv
// Reflected CRC-32 (Ethernet FCS) register, one octet per cycle, LSB of the octet first.
module crc32_d8
    import gmii_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        init_i,
    input  logic        en_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    localparam logic [31:0] POLY_REFL = bitrev32(CRC32_POLY);

    logic [31:0] crc_q;
    logic [31:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        for (int unsigned i = 0; i < 8; i++) begin
            if (crc_d[0] ^ data_i[i]) begin
                crc_d = {1'b0, crc_d[31:1]} ^ POLY_REFL;
            end else begin
                crc_d = {1'b0, crc_d[31:1]};
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            crc_q <= '1;
        end else if (init_i) begin
            crc_q <= '1;
        end else if (en_i) begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/gmii_testframe_parser.sv
// GMII receive parser: frame delineation, FCS check, SFD timestamp, trailer extraction
// and one-way latency against the transmit timestamp embedded before the FCS.
module gmii_testframe_parser
    import gmii_pkg::*;
#(
    parameter int unsigned C_MIN_TESTFRAME   = 64,
    parameter int unsigned C_MAX_LATENCY_SEC = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  gmii_d,
    input  logic        gmii_en,
    input  logic        gmii_er,
    input  logic [47:0] sec,
    input  logic [29:0] nsec,
    output logic        res_valid,
    output logic [15:0] res_octets,
    output logic        res_fcs_ok,
    output logic        res_testframe,
    output logic [63:0] res_seq,
    output logic [47:0] res_tx_sec,
    output logic [31:0] res_tx_nsec,
    output logic [47:0] res_rx_sec,
    output logic [29:0] res_rx_nsec,
    output logic [31:0] res_latency_nsec
);

    localparam logic [15:0] MIN_OCTETS = 16'(C_MIN_TESTFRAME);
    localparam logic [47:0] MAX_SEC    = 48'(C_MAX_LATENCY_SEC);

    rx_state_e state_q, state_d;
    logic      sfd_hit, data_byte, frame_end;

    logic        seen_idle_q;
    logic [47:0] cap_sec_q;
    logic [29:0] cap_nsec_q;
    logic [15:0] octets_q;
    logic        err_q;
    logic [175:0] sr_q;
    logic [31:0] crc;

    logic              end_q;
    logic              fin_valid_q;
    testframe_result_t fin_q, fin_d;
    logic              lat_valid_q;
    logic [31:0]       lat_q, lat_d;
    logic              res_valid_q;
    testframe_result_t res_q;
    logic [31:0]       res_lat_q;

    crc32_d8 u_crc (
        .clk_i  (clk),
        .rst_ni (resetn),
        .init_i (sfd_hit),
        .en_i   (data_byte),
        .data_i (gmii_d),
        .crc_o  (crc)
    );

    // seen_idle_q stays low until en=0 is observed, so a reset released mid-frame lands in DROP.
    always_comb begin
        state_d   = state_q;
        sfd_hit   = 1'b0;
        data_byte = 1'b0;
        frame_end = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (gmii_en) begin
                    state_d = (seen_idle_q && gmii_d == PREAMBLE_BYTE) ? ST_PRE : ST_DROP;
                end
            end
            ST_PRE: begin
                if (!gmii_en) begin
                    state_d = ST_IDLE;
                end else if (gmii_d == SFD_BYTE) begin
                    state_d = ST_DATA;
                    sfd_hit = 1'b1;
                end else if (gmii_d != PREAMBLE_BYTE) begin
                    state_d = ST_DROP;
                end
            end
            ST_DATA: begin
                if (gmii_en) begin
                    data_byte = 1'b1;
                end else begin
                    frame_end = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (!gmii_en) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            seen_idle_q <= 1'b0;
            cap_sec_q   <= '0;
            cap_nsec_q  <= '0;
            octets_q    <= '0;
            err_q       <= 1'b0;
            sr_q        <= '0;
            end_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            seen_idle_q <= seen_idle_q | ~gmii_en;
            end_q       <= frame_end;
            if (sfd_hit) begin
                cap_sec_q  <= sec;
                cap_nsec_q <= nsec;
                octets_q   <= '0;
                err_q      <= 1'b0;
                sr_q       <= '0;
            end else if (data_byte) begin
                if (octets_q != 16'hFFFF) begin
                    octets_q <= octets_q + 16'd1;
                end
                if (gmii_er) begin
                    err_q <= 1'b1;
                end
                sr_q <= {sr_q[167:0], gmii_d};
            end
        end
    end

    // Capture registers stay untouched until the next SFD (at least two cycles away), so the freeze reads them directly.
    always_comb begin
        fin_d         = '0;
        fin_d.octets  = octets_q;
        fin_d.rx_sec  = cap_sec_q;
        fin_d.rx_nsec = cap_nsec_q;
        fin_d.fcs_ok  = (bitrev32(crc) == CRC32_RESIDUE) && !err_q;
        if (octets_q >= TRAILER_OCTETS) begin
            fin_d.seq     = sr_q[175:112];
            fin_d.tx_sec  = sr_q[111:64];
            fin_d.tx_nsec = sr_q[63:32];
        end
        fin_d.testframe = fin_d.fcs_ok && (octets_q >= TRAILER_OCTETS) &&
                          (octets_q >= MIN_OCTETS) && (fin_d.tx_nsec < NSEC_PER_SEC);
    end

    // Beyond 4 s of difference no latency fits in 32 bits, so only dsec[2:0] enters the product.
    logic [47:0] dsec;
    logic [63:0] span;
    always_comb begin
        dsec  = fin_q.rx_sec - fin_q.tx_sec;
        span  = 64'(dsec[2:0]) * 64'(NSEC_PER_SEC) + 64'(fin_q.rx_nsec) - 64'(fin_q.tx_nsec);
        lat_d = '1;
        if (fin_q.testframe && dsec <= MAX_SEC && dsec < 48'd8 && span < 64'h0000_0000_FFFF_FFFF) begin
            lat_d = span[31:0];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fin_valid_q <= 1'b0;
            fin_q       <= '0;
            lat_valid_q <= 1'b0;
            lat_q       <= '0;
            res_valid_q <= 1'b0;
            res_q       <= '0;
            res_lat_q   <= '0;
        end else begin
            fin_valid_q <= end_q;
            lat_valid_q <= fin_valid_q;
            res_valid_q <= lat_valid_q;
            if (end_q) begin
                fin_q <= fin_d;
            end
            if (fin_valid_q) begin
                lat_q <= lat_d;
            end
            if (lat_valid_q) begin
                res_q     <= fin_q;
                res_lat_q <= lat_q;
            end
        end
    end

    assign res_valid        = res_valid_q;
    assign res_octets       = res_q.octets;
    assign res_fcs_ok       = res_q.fcs_ok;
    assign res_testframe    = res_q.testframe;
    assign res_seq          = res_q.seq;
    assign res_tx_sec       = res_q.tx_sec;
    assign res_tx_nsec      = res_q.tx_nsec;
    assign res_rx_sec       = res_q.rx_sec;
    assign res_rx_nsec      = res_q.rx_nsec;
    assign res_latency_nsec = res_lat_q;

endmodule
